nios2_qsys_oci_dct_unpacker: RTL and testbench

Receive-side counterpart of the OCI data-trace packer. It accepts packed trace frames (`dct_buffer` plus `dct_count`) over a valid/ready handshake and replays them as a stream of 2-bit trace atoms, one per cycle, to the trace sink or the bench monitor. It sits between the OCI trace packer and the trace FIFO/JTAG trace port. It provides a one-frame hold register so back-to-back frames replay without bubbles.

---
 rtl/nios2_qsys_oci_dct_pkg.sv | 20 ++
 rtl/nios2_qsys_oci_dct_hold_reg.sv | 33 +++
 rtl/nios2_qsys_oci_dct_unpacker.sv | 124 ++++++++++++
 tb/tb_nios2_qsys_oci_dct_unpacker.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_qsys_oci_dct_pkg.sv
// rtl/nios2_qsys_oci_dct_pkg.sv - shared widths, state and frame types for the OCI trace unpacker
package nios2_qsys_oci_dct_pkg;

  localparam int ATOM_W  = 2;
  localparam int SLOTS   = 15;
  localparam int CNT_W   = 4;
  localparam int FRAME_W = ATOM_W * SLOTS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } dct_state_t;

  // buf_data carries the packed atoms; the word "buf" alone is a reserved gate keyword
  typedef struct packed {
    logic [FRAME_W-1:0] buf_data;
    logic [CNT_W-1:0]   cnt;
  } dct_frame_t;

endpackage

// File: rtl/nios2_qsys_oci_dct_hold_reg.sv
// rtl/nios2_qsys_oci_dct_hold_reg.sv - one-frame hold register with full flag
module nios2_qsys_oci_dct_hold_reg
  import nios2_qsys_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               clear,
  input  logic [FRAME_W-1:0] in_buf,
  input  logic [CNT_W-1:0]   in_cnt,
  output logic [FRAME_W-1:0] h_buf,
  output logic [CNT_W-1:0]   h_cnt,
  output logic               h_full
);

  dct_frame_t frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame  <= '0;
      h_full <= 1'b0;
    end else if (load) begin
      frame  <= '{buf_data: in_buf, cnt: in_cnt};
      h_full <= 1'b1;
    end else if (clear) begin
      h_full <= 1'b0;
    end
  end

  assign h_buf = frame.buf_data;
  assign h_cnt = frame.cnt;

endmodule

// File: rtl/nios2_qsys_oci_dct_unpacker.sv
// rtl/nios2_qsys_oci_dct_unpacker.sv - replays packed trace frames as 2-bit atoms
// Statistics counters are built only when OCI_DCT_UNPACKER_STATS_EN is defined.
module nios2_qsys_oci_dct_unpacker #(
  parameter int ATOM_W = nios2_qsys_oci_dct_pkg::ATOM_W,
  parameter int SLOTS  = nios2_qsys_oci_dct_pkg::SLOTS,
  parameter int CNT_W  = nios2_qsys_oci_dct_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ATOM_W*SLOTS-1:0] dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  output logic                    atom_valid,
  input  logic                    atom_ready,
  output logic [ATOM_W-1:0]       atom_data,
  output logic                    atom_last,
  input  logic                    flush,
  output logic                    busy,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             atom_cnt
);

  import nios2_qsys_oci_dct_pkg::dct_state_t;
  import nios2_qsys_oci_dct_pkg::IDLE;
  import nios2_qsys_oci_dct_pkg::SHIFT;

  dct_state_t              state, state_d;
  logic [ATOM_W*SLOTS-1:0] sh_buf, sh_buf_d;
  logic [CNT_W-1:0]        sh_rem, sh_rem_d;
  logic [ATOM_W*SLOTS-1:0] h_buf;
  logic [CNT_W-1:0]        h_cnt;
  logic                    h_full;
  logic                    hold_load, hold_clear;
  logic                    accept, in_nz, atom_hs, last_hs, shifter_free;

  assign in_ready     = ~h_full & ~flush;
  assign accept       = in_valid & in_ready;
  assign in_nz        = (dct_count != '0);
  assign atom_valid   = (state == SHIFT);
  assign atom_last    = atom_valid & (sh_rem == CNT_W'(1));
  assign atom_data    = atom_valid ? sh_buf[ATOM_W-1:0] : '0;
  assign atom_hs      = atom_valid & atom_ready;
  assign last_hs      = atom_hs & atom_last;
  assign shifter_free = (state == IDLE) | last_hs;
  assign busy         = (state == SHIFT) | h_full;

  always_comb begin
    state_d    = state;
    sh_buf_d   = sh_buf;
    sh_rem_d   = sh_rem;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      sh_rem_d   = '0;
      hold_clear = 1'b1;
    end else begin
      // A held frame always precedes new input; in_ready is low whenever one is held.
      if (shifter_free && h_full) begin
        state_d    = SHIFT;
        sh_buf_d   = h_buf;
        sh_rem_d   = h_cnt;
        hold_clear = 1'b1;
      end else if (shifter_free && accept && in_nz) begin
        state_d  = SHIFT;
        sh_buf_d = dct_buffer;
        sh_rem_d = dct_count;
      end else if (last_hs) begin
        state_d  = IDLE;
        sh_rem_d = '0;
      end else if (atom_hs) begin
        sh_buf_d = sh_buf >> ATOM_W;
        sh_rem_d = sh_rem - CNT_W'(1);
      end
      hold_load = accept & in_nz & ~shifter_free;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sh_buf <= '0;
      sh_rem <= '0;
    end else begin
      state  <= state_d;
      sh_buf <= sh_buf_d;
      sh_rem <= sh_rem_d;
    end
  end

  nios2_qsys_oci_dct_hold_reg u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (hold_load),
    .clear   (hold_clear),
    .in_buf  (dct_buffer),
    .in_cnt  (dct_count),
    .h_buf   (h_buf),
    .h_cnt   (h_cnt),
    .h_full  (h_full)
  );

`ifdef OCI_DCT_UNPACKER_STATS_EN
  logic [15:0] frame_cnt_q, atom_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      atom_cnt_q  <= '0;
    end else begin
      if (last_hs) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (atom_hs) atom_cnt_q  <= atom_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign atom_cnt  = atom_cnt_q;
`else
  assign frame_cnt = '0;
  assign atom_cnt  = '0;
`endif

endmodule

// File: tb/tb_nios2_qsys_oci_dct_unpacker.sv
// tb/tb_nios2_qsys_oci_dct_unpacker.sv - directed self-checking bench for the trace unpacker
module tb_nios2_qsys_oci_dct_unpacker;

`ifdef OCI_DCT_UNPACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        atom_valid;
  logic        atom_ready = 1'b1;
  logic [1:0]  atom_data;
  logic        atom_last;
  logic        flush = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] atom_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc;
  bit acc_ok;
  int exp_frames = 0;
  int exp_atoms = 0;

  logic [1:0] q_data[$];
  logic       q_last[$];
  int         q_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && atom_valid && atom_ready) begin
      q_data.push_back(atom_data);
      q_last.push_back(atom_last);
      q_cyc.push_back(cyc);
    end
  end

  nios2_qsys_oci_dct_unpacker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .atom_valid (atom_valid),
    .atom_ready (atom_ready),
    .atom_data  (atom_data),
    .atom_last  (atom_last),
    .flush      (flush),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .atom_cnt   (atom_cnt)
  );

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  // Offers one frame and returns #1 after the edge that accepted it.
  task automatic send(input logic [29:0] b, input logic [3:0] c);
    acc_ok = 1'b0;
    in_valid = 1'b1;
    dct_buffer = b;
    dct_count = c;
    for (int i = 0; i < 50 && !acc_ok; i++) begin
      @(negedge clk);
      if (in_ready) acc_ok = 1'b1;
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc;
    in_valid = 1'b0;
    n_cmp++;
    if (acc_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL send_accept: frame count %0d not accepted within 50 cycles", c);
    end
  endtask

  task automatic check_counters(input string tag);
    n_cmp++;
    if (frame_cnt !== (STATS ? 16'(exp_frames) : 16'd0)) begin
      n_bad++;
      $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, STATS ? exp_frames : 0);
    end
    n_cmp++;
    if (atom_cnt !== (STATS ? 16'(exp_atoms) : 16'd0)) begin
      n_bad++;
      $display("FAIL %s atom_cnt: got %0d want %0d", tag, atom_cnt, STATS ? exp_atoms : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({atom_valid, atom_data, atom_last, in_ready, busy} !== 6'b0_00_0_1_0) begin
      n_bad++;
      $display("FAIL %s outputs: got v=%b d=%0d l=%b rdy=%b busy=%b want v=0 d=0 l=0 rdy=1 busy=0",
               tag, atom_valid, atom_data, atom_last, in_ready, busy);
    end
    n_cmp++;
    if (frame_cnt !== 16'd0 || atom_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL %s counters: got frame=%0d atom=%0d want 0/0", tag, frame_cnt, atom_cnt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_count3();
    clear_q();
    atom_ready = 1'b1;
    send(30'h39, 4'd3);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (q_data.size() !== 3) begin
      n_bad++;
      $display("FAIL count3_len: got %0d atoms want 3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q_data[i] !== 2'(i + 1) || q_last[i] !== (i == 2) || q_cyc[i] !== acc_cyc + i) begin
          n_bad++;
          $display("FAIL count3_atom%0d: got d=%0d l=%b cyc=%0d want d=%0d l=%b cyc=%0d",
                   i, q_data[i], q_last[i], q_cyc[i], i + 1, i == 2, acc_cyc + i);
        end
      end
    end
    exp_frames += 1;
    exp_atoms += 3;
    check_counters("count3");
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_d[3];
    logic       exp_l[3];
    int         a0;
    exp_d = '{2'd2, 2'd1, 2'd3};
    exp_l = '{1'b0, 1'b1, 1'b1};
    clear_q();
    send(30'h6, 4'd2);
    a0 = acc_cyc;
    send(30'h3, 4'd1);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_low: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_back: got %b want 1", in_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (q_data.size() !== 3) begin
      n_bad++;
      $display("FAIL b2b_len: got %0d atoms want 3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q_data[i] !== exp_d[i] || q_last[i] !== exp_l[i] || q_cyc[i] !== a0 + i) begin
          n_bad++;
          $display("FAIL b2b_atom%0d: got d=%0d l=%b cyc=%0d want d=%0d l=%b cyc=%0d",
                   i, q_data[i], q_last[i], q_cyc[i], exp_d[i], exp_l[i], a0 + i);
        end
      end
    end
    exp_frames += 2;
    exp_atoms += 3;
    check_counters("b2b");
  endtask

  task automatic test_backpressure();
    int waited;
    clear_q();
    atom_ready = 1'b1;
    send(30'h3FFF_FFFF, 4'd15);
    repeat (3) @(posedge clk);
    #1;
    atom_ready = 1'b0;
    send(30'h9, 4'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (atom_valid !== 1'b1 || atom_data !== 2'd3 || atom_last !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_stall%0d: got v=%b d=%0d l=%b rdy=%b want v=1 d=3 l=0 rdy=0",
                 i, atom_valid, atom_data, atom_last, in_ready);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (q_data.size() !== 3) begin
      n_bad++;
      $display("FAIL bp_stalled_len: got %0d atoms want 3", q_data.size());
    end
    atom_ready = 1'b1;
    waited = 0;
    while (q_data.size() < 17 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q_data.size() !== 17) begin
      n_bad++;
      $display("FAIL bp_len: got %0d atoms want 17", q_data.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        n_cmp++;
        if (q_data[i] !== (i < 15 ? 2'd3 : (i == 15 ? 2'd1 : 2'd2)) ||
            q_last[i] !== (i == 14 || i == 16)) begin
          n_bad++;
          $display("FAIL bp_atom%0d: got d=%0d l=%b want d=%0d l=%b", i, q_data[i], q_last[i],
                   i < 15 ? 3 : (i == 15 ? 1 : 2), i == 14 || i == 16);
        end
      end
      n_cmp++;
      if (q_cyc[15] !== q_cyc[14] + 1) begin
        n_bad++;
        $display("FAIL bp_no_bubble: got gap %0d want 1", q_cyc[15] - q_cyc[14]);
      end
    end
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drained: got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
    end
    exp_frames += 2;
    exp_atoms += 17;
    check_counters("bp");
  endtask

  task automatic test_count_zero();
    clear_q();
    send(30'h3, 4'd0);
    n_cmp++;
    if (atom_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_dropped: got v=%b busy=%b want v=0 busy=0", atom_valid, busy);
    end
    send(30'h2, 4'd1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (q_data.size() !== 1) begin
      n_bad++;
      $display("FAIL zero_len: got %0d atoms want 1", q_data.size());
    end else begin
      n_cmp++;
      if (q_data[0] !== 2'd2 || q_last[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL zero_atom: got d=%0d l=%b want d=2 l=1", q_data[0], q_last[0]);
      end
    end
    exp_frames += 1;
    exp_atoms += 1;
    check_counters("zero");
  endtask

  task automatic test_flush();
    clear_q();
    atom_ready = 1'b1;
    send(30'h55555, 4'd10);
    send(30'h39, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q_data.size() !== 3 || atom_valid !== 1'b1 || atom_data !== 2'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre: got n=%0d v=%b d=%0d busy=%b want n=3 v=1 d=1 busy=1",
               q_data.size(), atom_valid, atom_data, busy);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_ready_forced: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    n_cmp++;
    if (atom_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_after: got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=1",
               atom_valid, busy, in_ready);
    end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (q_data.size() !== 4) begin
      n_bad++;
      $display("FAIL flush_len: got %0d atoms want 4", q_data.size());
    end
    exp_atoms += 4;
    check_counters("flush");
  endtask

  task automatic test_reset_mid_frame();
    clear_q();
    atom_ready = 1'b1;
    send(30'h39, 4'd3);
    @(posedge clk);
    #1;
    n_cmp++;
    if (atom_valid !== 1'b1 || atom_data !== 2'd2) begin
      n_bad++;
      $display("FAIL rstmid_pre: got v=%b d=%0d want v=1 d=2", atom_valid, atom_data);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    exp_frames = 0;
    exp_atoms = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (q_data.size() !== 1 || atom_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_discard: got n=%0d v=%b want n=1 v=0", q_data.size(), atom_valid);
    end
    check_counters("rstmid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count3();
    test_back_to_back();
    test_backpressure();
    test_count_zero();
    test_flush();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
